// File: rtl/pri_iter.sv
// Iterative priority grant engine: captures a request vector, then hands out
// one grant per accepted handshake, highest priority first, until empty.
module pri_iter #(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned GROUP     = 8,
    parameter logic        MSB_FIRST = 1'b0,
    localparam int unsigned IW       = $clog2(WIDTH),
    localparam int unsigned CW       = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             init_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             flush_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] onehot_o,
    output logic [IW-1:0]    index_o,
    output logic             last_o,
    input  logic             ack_i,
    output logic             done_o,
    output logic [CW-1:0]    count_o
);

    localparam int unsigned NG = WIDTH / GROUP;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH-1:0] pend_ord;
    logic [NG-1:0]    grp;
    logic [GROUP-1:0] grp_bits [NG];
    logic [GROUP-1:0] gbits;
    logic [IW-1:0]    gbase;
    logic [IW-1:0]    ord_idx;
    logic [IW-1:0]    grant_idx;
    logic [WIDTH-1:0] grant_oh;
    logic             pend_one;

    // Reorder so that bit 0 of pend_ord is always the highest priority.
    for (genvar i = 0; i < WIDTH; i++) begin : g_ord
        assign pend_ord[i] = MSB_FIRST ? pend_q[WIDTH-1-i] : pend_q[i];
    end

    for (genvar g = 0; g < NG; g++) begin : g_grp
        assign grp_bits[g] = pend_ord[g*GROUP +: GROUP];
        assign grp[g]      = |grp_bits[g];
    end

    // Level 1: lowest set group wins; level 2: lowest set bit inside it.
    always_comb begin
        gbase   = '0;
        gbits   = '0;
        ord_idx = '0;
        for (int g = int'(NG) - 1; g >= 0; g--) begin
            if (grp[g]) begin
                gbase = IW'(g * GROUP);
                gbits = grp_bits[g];
            end
        end
        ord_idx = gbase;
        for (int b = int'(GROUP) - 1; b >= 0; b--) begin
            if (gbits[b]) begin
                ord_idx = gbase + IW'(b);
            end
        end
    end

    assign grant_idx = MSB_FIRST ? (IW'(WIDTH - 1) - ord_idx) : ord_idx;
    assign grant_oh  = WIDTH'(1) << grant_idx;
    assign pend_one  = (pend_q != '0) && ((pend_q & (pend_q - WIDTH'(1))) == '0);

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath update; flush overrides everything.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            state_d = ST_IDLE;
            pend_d  = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (init_i) begin
                        cnt_d = '0;
                        if (data_i != '0) begin
                            pend_d  = data_i;
                            state_d = ST_BUSY;
                        end else begin
                            state_d = ST_FIN;
                        end
                    end
                end
                ST_BUSY: begin
                    if (ack_i) begin
                        pend_d = pend_q & ~grant_oh;
                        cnt_d  = cnt_q + CW'(1);
                        if (pend_one) begin
                            state_d = ST_FIN;
                        end
                    end
                end
                ST_FIN: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Moore outputs decoded from the registered state and pending map.
    always_comb begin
        ready_o  = 1'b0;
        valid_o  = 1'b0;
        done_o   = 1'b0;
        onehot_o = '0;
        index_o  = '0;
        last_o   = 1'b0;
        count_o  = cnt_q;
        unique case (state_q)
            ST_IDLE: ready_o = 1'b1;
            ST_BUSY: begin
                valid_o  = 1'b1;
                onehot_o = grant_oh;
                index_o  = grant_idx;
                last_o   = pend_one;
            end
            ST_FIN:  done_o = 1'b1;
            default: ready_o = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_pri_iter.sv
// Bench for pri_iter: LSB-first and MSB-first instances driven in parallel and
// compared every cycle against a set-bit-walking reference model.
module tb_pri_iter;

    localparam int unsigned W  = 64;
    localparam int unsigned IW = 6;
    localparam int unsigned CW = 7;

    logic          clk_i;
    logic          rst_n_i;
    logic          init_i;
    logic          flush_i;
    logic          ack_i;
    logic [W-1:0]  data_i;

    logic          ready  [2];
    logic          valid  [2];
    logic          last   [2];
    logic          done   [2];
    logic [W-1:0]  onehot [2];
    logic [IW-1:0] index  [2];
    logic [CW-1:0] count  [2];

    pri_iter #(.WIDTH(64), .GROUP(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .init_i(init_i), .data_i(data_i),
        .flush_i(flush_i), .ready_o(ready[0]), .valid_o(valid[0]),
        .onehot_o(onehot[0]), .index_o(index[0]), .last_o(last[0]),
        .ack_i(ack_i), .done_o(done[0]), .count_o(count[0])
    );

    pri_iter #(.WIDTH(64), .GROUP(8), .MSB_FIRST(1'b1)) u_msb (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .init_i(init_i), .data_i(data_i),
        .flush_i(flush_i), .ready_o(ready[1]), .valid_o(valid[1]),
        .onehot_o(onehot[1]), .index_o(index[1]), .last_o(last[1]),
        .ack_i(ack_i), .done_o(done[1]), .count_o(count[1])
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: 0=idle, 1=granting, 2=finished; grants walk set bits in order.
    int          m_st   [2];
    logic [63:0] m_pend [2];
    int          m_cnt  [2];

    function automatic int first_idx(input logic [63:0] v, input bit msb);
        for (int j = 0; j < 64; j++) begin
            int i;
            i = msb ? 63 - j : j;
            if (v[i]) return i;
        end
        return 0;
    endfunction

    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int m = 0; m < 2; m++) begin
                m_st[m]   <= 0;
                m_pend[m] <= '0;
                m_cnt[m]  <= 0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                if (flush_i) begin
                    m_st[m]   <= 0;
                    m_pend[m] <= '0;
                    m_cnt[m]  <= 0;
                end else if (m_st[m] == 0) begin
                    if (init_i) begin
                        m_cnt[m] <= 0;
                        if (data_i != 0) begin
                            m_pend[m] <= data_i;
                            m_st[m]   <= 1;
                        end else begin
                            m_st[m] <= 2;
                        end
                    end
                end else if (m_st[m] == 1) begin
                    if (ack_i) begin
                        m_pend[m] <= m_pend[m] & ~(64'd1 << first_idx(m_pend[m], m == 1));
                        m_cnt[m]  <= m_cnt[m] + 1;
                        if ($countones(m_pend[m]) == 1) m_st[m] <= 2;
                    end
                end else begin
                    m_st[m] <= 0;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk_i) begin
        for (int m = 0; m < 2; m++) begin
            bit v;
            int ei;
            v  = (m_st[m] == 1);
            ei = first_idx(m_pend[m], m == 1);
            chk($sformatf("ready%0d", m),  64'(ready[m]),  64'(m_st[m] == 0));
            chk($sformatf("valid%0d", m),  64'(valid[m]),  64'(v));
            chk($sformatf("done%0d", m),   64'(done[m]),   64'(m_st[m] == 2));
            chk($sformatf("onehot%0d", m), onehot[m],      v ? (64'd1 << ei) : 64'd0);
            chk($sformatf("index%0d", m),  64'(index[m]),  v ? 64'(ei) : 64'd0);
            chk($sformatf("last%0d", m),   64'(last[m]),   64'(v && ($countones(m_pend[m]) == 1)));
            chk($sformatf("count%0d", m),  64'(count[m]),  64'(m_cnt[m]));
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic load(input logic [63:0] d);
        init_i = 1'b1;
        data_i = d;
        tick();
        init_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cyc;
        logic [63:0] d;
        init_i = 1'b0; flush_i = 1'b0; ack_i = 1'b0; data_i = '0;
        rst_n_i = 1'b1;
        #1 rst_n_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #2;
        chk("rst_ready", 64'(ready[0]), 64'd1);
        chk("rst_valid", 64'(valid[0]), 64'd0);
        chk("rst_count", 64'(count[0]), 64'd0);
        rst_n_i = 1'b1;
        tick();

        // Sparse vector with continuous ack.
        ack_i = 1'b1;
        load(64'h8000_0000_0000_0011);
        chk("s1_idx0", 64'(index[0]), 64'd0);
        chk("s1_last0", 64'(last[0]), 64'd0);
        tick();
        chk("s1_idx4", 64'(index[0]), 64'd4);
        tick();
        chk("s1_idx63", 64'(index[0]), 64'd63);
        chk("s1_last63", 64'(last[0]), 64'd1);
        tick();
        chk("s1_done", 64'(done[0]), 64'd1);
        chk("s1_count", 64'(count[0]), 64'd3);
        tick();
        chk("s1_ready", 64'(ready[0]), 64'd1);

        // Zero vector.
        load(64'h0);
        chk("s2_done", 64'(done[0]), 64'd1);
        chk("s2_valid", 64'(valid[0]), 64'd0);
        chk("s2_count", 64'(count[0]), 64'd0);
        tick();
        chk("s2_ready", 64'(ready[0]), 64'd1);

        // Back-pressure holds the grant stable.
        ack_i = 1'b0;
        load(64'h5);
        chk("s3_oh", onehot[0], 64'h1);
        repeat (3) begin
            tick();
            chk("s3_hold_oh", onehot[0], 64'h1);
            chk("s3_hold_idx", 64'(index[0]), 64'd0);
        end
        ack_i = 1'b1;
        tick();
        chk("s3_idx2", 64'(index[0]), 64'd2);
        chk("s3_last", 64'(last[0]), 64'd1);
        tick();
        chk("s3_done", 64'(done[0]), 64'd1);
        tick();

        // MSB-first ordering on the second instance.
        load(64'h0100_0000_0000_0005);
        chk("s4_idx56", 64'(index[1]), 64'd56);
        tick();
        chk("s4_idx2", 64'(index[1]), 64'd2);
        tick();
        chk("s4_idx0", 64'(index[1]), 64'd0);
        chk("s4_last", 64'(last[1]), 64'd1);
        tick();
        chk("s4_done", 64'(done[1]), 64'd1);
        chk("s4_count", 64'(count[1]), 64'd3);
        tick();

        // Ignored init while busy, then flush together with ack.
        load(64'hFF);
        tick();
        tick();
        chk("s5_idx2", 64'(index[0]), 64'd2);
        ack_i = 1'b0; init_i = 1'b1; data_i = 64'h8000_0000_0000_0000;
        tick();
        init_i = 1'b0;
        chk("s5_busy_init_idx", 64'(index[0]), 64'd2);
        chk("s5_busy_init_cnt", 64'(count[0]), 64'd2);
        flush_i = 1'b1; ack_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("s5_ready", 64'(ready[0]), 64'd1);
        chk("s5_valid", 64'(valid[0]), 64'd0);
        chk("s5_count", 64'(count[0]), 64'd0);
        chk("s5_nodone", 64'(done[0]), 64'd0);
        tick();
        chk("s5_nodone2", 64'(done[0]), 64'd0);

        // Full vector, then asynchronous reset mid-walk.
        load(64'hFFFF_FFFF_FFFF_FFFF);
        for (int i = 0; i < 64; i++) begin
            chk("s6_idx", 64'(index[0]), 64'(i));
            tick();
        end
        chk("s6_done", 64'(done[0]), 64'd1);
        chk("s6_count", 64'(count[0]), 64'd64);
        tick();
        load(64'hFFFF_FFFF_FFFF_FFFF);
        repeat (10) tick();
        chk("s6_idx10", 64'(index[0]), 64'd10);
        #1 rst_n_i = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk("s6_rst_ready", 64'(ready[m]), 64'd1);
            chk("s6_rst_valid", 64'(valid[m]), 64'd0);
            chk("s6_rst_oh", onehot[m], 64'd0);
            chk("s6_rst_idx", 64'(index[m]), 64'd0);
            chk("s6_rst_last", 64'(last[m]), 64'd0);
            chk("s6_rst_done", 64'(done[m]), 64'd0);
            chk("s6_rst_count", 64'(count[m]), 64'd0);
        end
        @(posedge clk_i);
        #2 rst_n_i = 1'b1;
        tick();
        chk("s6_nodone", 64'(done[0]), 64'd0);

        // Randomized walks with random ack, stray inits and occasional flush.
        repeat (40) begin
            case ($urandom_range(0, 3))
                0: d = 64'h0;
                1: d = {$urandom, $urandom};
                2: d = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
                default: d = 64'd1 << $urandom_range(0, 63);
            endcase
            ack_i = 1'($urandom_range(0, 1));
            load(d);
            cyc = 0;
            while (!ready[0] && cyc < 1000) begin
                ack_i   = ($urandom_range(0, 3) != 0);
                init_i  = ($urandom_range(0, 7) == 0);
                data_i  = {$urandom, $urandom};
                flush_i = ($urandom_range(0, 49) == 0);
                tick();
                cyc++;
            end
            init_i = 1'b0; flush_i = 1'b0;
            chk("rand_timeout", 64'(cyc < 1000), 64'd1);
        end

        tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
